// File: rtl/phy_apb_init_seq.sv
`default_nettype none
// ============================================================================
//  Module   : phy_apb_init_seq
//  Purpose  : PCIe PHY bring-up sequencer and single-transfer APB master.
//             Issues the uC boot write, waits for uc_init_complete, releases
//             the PHY resets after RST_DLY cycles, then forwards host
//             register commands to the PHY APB slave.
//  Options  : `define PHY_APB_TIMEOUT_EN to abort ACCESS phases that stall
//             on pready for TIMEOUT_CYC cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module phy_apb_init_seq #(
    parameter int                AWIDTH      = 18,
    parameter int                DWIDTH      = 32,
    parameter logic [AWIDTH-1:0] BOOT_ADDR   = 18'h3_0068,
    parameter logic [DWIDTH-1:0] BOOT_DATA   = 32'h1000_0000,
    parameter int                RST_DLY     = 20,
    parameter int                TIMEOUT_CYC = 256
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              uc_init_complete,
    output logic              phy_reset_n,
    output logic              phy_p00_reset_n,
    output logic              init_done,
    output logic              init_err,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [AWIDTH-1:0] cmd_addr,
    input  logic [DWIDTH-1:0] cmd_wdata,
    input  logic              cmd_write,
    output logic              rsp_valid,
    output logic [DWIDTH-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [AWIDTH-1:0] paddr,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [DWIDTH-1:0] pwdata,
    input  logic [DWIDTH-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    typedef enum logic [2:0] {
        BOOT_SETUP  = 3'd0,
        BOOT_ACCESS = 3'd1,
        WAIT_UC     = 3'd2,
        DLY         = 3'd3,
        RUN         = 3'd4,
        CMD_SETUP   = 3'd5,
        CMD_ACCESS  = 3'd6,
        ERR         = 3'd7
    } state_t;

    localparam logic [7:0] c_dly_load = 8'(RST_DLY - 1);

    state_t              r_state;
    state_t              w_next;
    logic                r_armed;
    logic                r_uc_meta;
    logic                r_uc_sync;
    logic                r_uc_prev;
    logic                w_uc_rise;
    logic [7:0]          r_dly_cnt;
    logic                r_released;
    logic [AWIDTH-1:0]   r_cmd_addr;
    logic [DWIDTH-1:0]   r_cmd_wdata;
    logic                r_cmd_write;
    logic                r_rsp_valid;
    logic [DWIDTH-1:0]   r_rsp_rdata;
    logic                r_rsp_err;
    logic                w_bus_boot;
    logic                w_bus_cmd;
    logic                w_capture;
    logic                w_dly_load;
    logic                w_release;
    logic                w_xfer_done;
    logic                w_xfer_err;
    logic                w_tmo_hit;

    assign w_uc_rise = r_uc_sync & ~r_uc_prev;

`ifdef PHY_APB_TIMEOUT_EN
    localparam int                 c_tmo_w    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CYC - 1);

    logic [c_tmo_w-1:0] r_tmo_cnt;

    // The last permitted stalled ACCESS cycle ends the transfer.
    assign w_tmo_hit = penable & ~pready & (r_tmo_cnt == c_tmo_last);

    // Count ACCESS cycles stalled on pready; cleared whenever the bus is not waiting.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_tmo_cnt <= '0;
        end else if (penable & ~pready & ~w_tmo_hit) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end else begin
            r_tmo_cnt <= '0;
        end
    end
`else
    // No timeout in this build: ACCESS waits on pready for as long as it takes.
    assign w_tmo_hit = (TIMEOUT_CYC < 0);
`endif

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= BOOT_SETUP;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode plus the single-cycle control strobes for the datapath.
    always_comb begin
        w_next      = r_state;
        w_capture   = 1'b0;
        w_dly_load  = 1'b0;
        w_release   = 1'b0;
        w_xfer_done = 1'b0;
        w_xfer_err  = 1'b0;
        case (r_state)
            BOOT_SETUP: begin
                if (r_armed) begin
                    w_next = BOOT_ACCESS;
                end
            end
            BOOT_ACCESS: begin
                if (pready) begin
                    w_next = pslverr ? ERR : WAIT_UC;
                end else if (w_tmo_hit) begin
                    w_next = ERR;
                end
            end
            WAIT_UC: begin
                if (w_uc_rise) begin
                    w_next     = DLY;
                    w_dly_load = 1'b1;
                end
            end
            DLY: begin
                if (r_dly_cnt == 8'd0) begin
                    w_next    = RUN;
                    w_release = 1'b1;
                end
            end
            RUN: begin
                if (cmd_valid) begin
                    w_next    = CMD_SETUP;
                    w_capture = 1'b1;
                end
            end
            CMD_SETUP: begin
                w_next = CMD_ACCESS;
            end
            CMD_ACCESS: begin
                if (pready) begin
                    w_next      = RUN;
                    w_xfer_done = 1'b1;
                    w_xfer_err  = pslverr;
                end else if (w_tmo_hit) begin
                    w_next      = RUN;
                    w_xfer_done = 1'b1;
                    w_xfer_err  = 1'b1;
                end
            end
            ERR: begin
                w_next = ERR;
            end
            default: begin
                w_next = BOOT_SETUP;
            end
        endcase
    end

    // Datapath: reset-release arming, uc synchronizer, delay counter, command capture, response.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_armed     <= 1'b0;
            r_uc_meta   <= 1'b0;
            r_uc_sync   <= 1'b0;
            r_uc_prev   <= 1'b0;
            r_dly_cnt   <= 8'd0;
            r_released  <= 1'b0;
            r_cmd_addr  <= '0;
            r_cmd_wdata <= '0;
            r_cmd_write <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            // One idle clock after reset release keeps the APB outputs clear of
            // the asynchronous deassertion edge.
            r_armed   <= 1'b1;
            r_uc_meta <= uc_init_complete;
            r_uc_sync <= r_uc_meta;
            r_uc_prev <= r_uc_sync;
            if (w_dly_load) begin
                r_dly_cnt <= c_dly_load;
            end else if ((r_state == DLY) && (r_dly_cnt != 8'd0)) begin
                r_dly_cnt <= r_dly_cnt - 8'd1;
            end
            if (w_release) begin
                r_released <= 1'b1;
            end
            if (w_capture) begin
                r_cmd_addr  <= cmd_addr;
                r_cmd_wdata <= cmd_wdata;
                r_cmd_write <= cmd_write;
            end
            r_rsp_valid <= w_xfer_done;
            r_rsp_err   <= w_xfer_done & w_xfer_err;
            // Read data only when the slave actually completed a read.
            r_rsp_rdata <= (w_xfer_done & pready & ~r_cmd_write) ? prdata : '0;
        end
    end

    assign w_bus_boot = (r_state == BOOT_SETUP) || (r_state == BOOT_ACCESS);
    assign w_bus_cmd  = (r_state == CMD_SETUP)  || (r_state == CMD_ACCESS);

    assign psel    = r_armed & (w_bus_boot | w_bus_cmd);
    assign penable = r_armed & ((r_state == BOOT_ACCESS) || (r_state == CMD_ACCESS));
    assign paddr   = !psel ? '0 : (w_bus_boot ? BOOT_ADDR : r_cmd_addr);
    assign pwdata  = !psel ? '0 : (w_bus_boot ? BOOT_DATA : r_cmd_wdata);
    assign pwrite  = psel & (w_bus_boot | r_cmd_write);

    assign cmd_ready       = (r_state == RUN);
    assign init_err        = (r_state == ERR);
    assign phy_reset_n     = r_released;
    assign phy_p00_reset_n = r_released;
    assign init_done       = r_released;

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule
`default_nettype wire
